// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage_if
//  Description : Valid/ready data-memory port between the memory stage
//                (master) and the data memory (slave). The request side
//                carries address, store data and direction. The response
//                side returns load data with a valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
interface memory_stage_if #(
    parameter int N = 64
);
    logic         dm_req_valid;
    logic         dm_req_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_req_ready;
    logic         dm_rsp_valid;
    logic [N-1:0] dm_rdata;

    modport master (
        output dm_req_valid,
        output dm_req_we,
        output dm_addr,
        output dm_wdata,
        input  dm_req_ready,
        input  dm_rsp_valid,
        input  dm_rdata
    );

    modport slave (
        input  dm_req_valid,
        input  dm_req_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_req_ready,
        output dm_rsp_valid,
        output dm_rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : EX/MEM pipeline register and memory-access stage of the
//                64-bit LEGv8 pipeline. It latches execute results, issues
//                loads and stores on a valid/ready port, and stalls upstream
//                while an access is outstanding. It resolves the conditional
//                branch, traps misaligned doubleword accesses with a sticky
//                flag, and feeds the MEM/WB register.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_stage #(
    parameter int N           = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    // execute-stage results and control
    input  wire logic [N-1:0] aluResult_E,
    input  wire logic [N-1:0] writeData_E,
    input  wire logic [N-1:0] PCBranch_E,
    input  wire logic         zero_E,
    input  wire logic         Branch_E,
    input  wire logic         MemRead_E,
    input  wire logic         MemWrite_E,
    input  wire logic         RegWrite_E,
    input  wire logic         MemtoReg_E,
    input  wire logic [4:0]   rd_E,
    input  wire logic         flush_M,
    // data-memory port
    memory_stage_if.master    dm,
    // pipeline control
    output logic              stall_M,
    output logic              PCSrc_M,
    output logic [N-1:0]      PCBranch_M,
    output logic              mem_fault,
    // writeback operands
    output logic [N-1:0]      aluResult_W,
    output logic [N-1:0]      readData_W,
    output logic              RegWrite_W,
    output logic              MemtoReg_W,
    output logic [4:0]        rd_W
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    // EX/MEM latch
    logic [N-1:0] r_aluResult_M;
    logic [N-1:0] r_writeData_M;
    logic [N-1:0] r_PCBranch_M;
    logic         r_zero_M;
    logic         r_Branch_M;
    logic         r_MemRead_M;
    logic         r_MemWrite_M;
    logic         r_RegWrite_M;
    logic         r_MemtoReg_M;
    logic [4:0]   r_rd_M;

    // access sequencer
    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         w_req_valid;
    logic         w_stall;

    // MEM/WB register and fault flag
    logic [N-1:0] r_aluResult_W;
    logic [N-1:0] r_readData_W;
    logic         r_RegWrite_W;
    logic         r_MemtoReg_W;
    logic [4:0]   r_rd_W;
    logic         r_mem_fault;

    logic         w_memop_M;
    logic         w_misal_M;
    logic         w_issue_E;

    assign w_memop_M = r_MemRead_M | r_MemWrite_M;
    assign w_misal_M = ALIGN_CHECK & w_memop_M & (r_aluResult_M[2:0] != 3'b000);

    // The incoming instruction needs a bus access only if it survives the
    // flush and is an aligned memory op. This decides the state entered on
    // the latching edge.
    assign w_issue_E = ~flush_M & (MemRead_E | MemWrite_E)
                     & ~(ALIGN_CHECK & (aluResult_E[2:0] != 3'b000));

    // EX/MEM latch: advance whenever the stage is not stalled; a flush kills control only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluResult_M <= '0;
            r_writeData_M <= '0;
            r_PCBranch_M  <= '0;
            r_zero_M      <= 1'b0;
            r_Branch_M    <= 1'b0;
            r_MemRead_M   <= 1'b0;
            r_MemWrite_M  <= 1'b0;
            r_RegWrite_M  <= 1'b0;
            r_MemtoReg_M  <= 1'b0;
            r_rd_M        <= 5'd0;
        end else if (!w_stall) begin
            r_aluResult_M <= aluResult_E;
            r_writeData_M <= writeData_E;
            r_PCBranch_M  <= PCBranch_E;
            r_zero_M      <= zero_E;
            r_rd_M        <= rd_E;
            r_Branch_M    <= Branch_E   & ~flush_M;
            r_MemRead_M   <= MemRead_E  & ~flush_M;
            r_MemWrite_M  <= MemWrite_E & ~flush_M;
            r_RegWrite_M  <= RegWrite_E & ~flush_M;
            r_MemtoReg_M  <= MemtoReg_E & ~flush_M;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state, request strobe and stall. Once the stage stops
    // stalling, the latch advances on the same edge, so the next state comes
    // from the incoming instruction. This lets back-to-back accesses run with
    // no idle gap.
    always_comb begin
        w_req_valid = 1'b0;
        w_stall     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_REQ: begin
                w_req_valid = 1'b1;
                w_stall     = ~(dm.dm_req_ready & r_MemWrite_M);
                if (w_stall) begin
                    w_state_nxt = dm.dm_req_ready ? c_WAIT : c_REQ;
                end else begin
                    w_state_nxt = w_issue_E ? c_REQ : c_IDLE;
                end
            end
            c_WAIT: begin
                // The response is never looked at in the accept cycle;
                // it is only sampled from here on.
                w_stall = ~dm.dm_rsp_valid;
                if (!w_stall) begin
                    w_state_nxt = w_issue_E ? c_REQ : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = w_issue_E ? c_REQ : c_IDLE;
            end
        endcase
    end

    // MEM/WB register: a stall cycle sends a bubble but keeps the data fields
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluResult_W <= '0;
            r_readData_W  <= '0;
            r_RegWrite_W  <= 1'b0;
            r_MemtoReg_W  <= 1'b0;
            r_rd_W        <= 5'd0;
        end else if (w_stall) begin
            r_RegWrite_W  <= 1'b0;
            r_MemtoReg_W  <= 1'b0;
        end else begin
            r_aluResult_W <= r_aluResult_M;
            // Only a load finishing out of WAIT carries valid read data.
            r_readData_W  <= (r_state == c_WAIT) ? dm.dm_rdata : '0;
            r_RegWrite_W  <= r_RegWrite_M & ~w_misal_M;
            r_MemtoReg_W  <= r_MemtoReg_M;
            r_rd_W        <= r_rd_M;
        end
    end

    // Sticky misaligned-access flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_fault <= 1'b0;
        end else begin
            r_mem_fault <= r_mem_fault | w_misal_M;
        end
    end

    // Memory request: address and data come straight from the latch, so
    // they stay stable for as long as the request waits for ready.
    assign dm.dm_req_valid = w_req_valid;
    assign dm.dm_req_we    = w_req_valid & r_MemWrite_M;
    assign dm.dm_addr      = r_aluResult_M;
    assign dm.dm_wdata     = r_writeData_M;

    assign stall_M     = w_stall;
    assign PCSrc_M     = r_Branch_M & r_zero_M;
    assign PCBranch_M  = r_PCBranch_M;
    assign mem_fault   = r_mem_fault;

    assign aluResult_W = r_aluResult_W;
    assign readData_W  = r_readData_W;
    assign RegWrite_W  = r_RegWrite_W;
    assign MemtoReg_W  = r_MemtoReg_W;
    assign rd_W        = r_rd_W;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_stage
//  Description : Directed self-checking bench for memory_stage. It covers an
//                ALU op, a store, a stalled load, branch and flush,
//                misalignment, reset during WAIT and back-to-back stores.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_stage;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic [N-1:0] aluResult_E;
    logic [N-1:0] writeData_E;
    logic [N-1:0] PCBranch_E;
    logic         zero_E;
    logic         Branch_E;
    logic         MemRead_E;
    logic         MemWrite_E;
    logic         RegWrite_E;
    logic         MemtoReg_E;
    logic [4:0]   rd_E;
    logic         flush_M;
    logic         stall_M;
    logic         PCSrc_M;
    logic [N-1:0] PCBranch_M;
    logic         mem_fault;
    logic [N-1:0] aluResult_W;
    logic [N-1:0] readData_W;
    logic         RegWrite_W;
    logic         MemtoReg_W;
    logic [4:0]   rd_W;

    int n_checks = 0;
    int n_errors = 0;

    memory_stage_if #(.N(N)) dm_if ();

    memory_stage #(.N(N), .ALIGN_CHECK(1'b1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .PCBranch_E  (PCBranch_E),
        .zero_E      (zero_E),
        .Branch_E    (Branch_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .RegWrite_E  (RegWrite_E),
        .MemtoReg_E  (MemtoReg_E),
        .rd_E        (rd_E),
        .flush_M     (flush_M),
        .dm          (dm_if.master),
        .stall_M     (stall_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .mem_fault   (mem_fault),
        .aluResult_W (aluResult_W),
        .readData_W  (readData_W),
        .RegWrite_W  (RegWrite_W),
        .MemtoReg_W  (MemtoReg_W),
        .rd_W        (rd_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
        zero_E = 1'b0; Branch_E = 1'b0; MemRead_E = 1'b0; MemWrite_E = 1'b0;
        RegWrite_E = 1'b0; MemtoReg_E = 1'b0; rd_E = 5'd0; flush_M = 1'b0;
    endtask

    // load handshake script: ready in cycle 3, response 3 cycles later
    logic rdy_tbl  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic rsp_tbl  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic stl_tbl  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int stall_cycles;
        nop();
        reset = 1'b1;
        dm_if.dm_req_ready = 1'b0;
        dm_if.dm_rsp_valid = 1'b0;
        dm_if.dm_rdata     = '0;
        tick();
        tick();

        // reset state
        check("rst_stall",  stall_M, 0);
        check("rst_valid",  dm_if.dm_req_valid, 0);
        check("rst_pcsrc",  PCSrc_M, 0);
        check("rst_fault",  mem_fault, 0);
        check("rst_regw",   RegWrite_W, 0);
        check("rst_aluw",   aluResult_W, 0);
        check("rst_rdw",    rd_W, 0);
        reset = 1'b0;

        // ADD: result reaches WB two edges later
        aluResult_E = 64'h10; rd_E = 5'd3; RegWrite_E = 1'b1;
        tick();
        nop();
        check("add_stall", stall_M, 0);
        tick();
        check("add_regw", RegWrite_W, 1);
        check("add_aluw", aluResult_W, 64'h10);
        check("add_rdw",  rd_W, 3);
        check("add_m2r",  MemtoReg_W, 0);

        // STUR with immediate ready
        dm_if.dm_req_ready = 1'b1;
        aluResult_E = 64'h40; writeData_E = 64'hDEAD; MemWrite_E = 1'b1;
        tick();
        nop();
        check("st_valid", dm_if.dm_req_valid, 1);
        check("st_we",    dm_if.dm_req_we, 1);
        check("st_addr",  dm_if.dm_addr, 64'h40);
        check("st_wdata", dm_if.dm_wdata, 64'hDEAD);
        check("st_stall", stall_M, 0);
        tick();
        check("st_valid_off", dm_if.dm_req_valid, 0);
        check("st_stall_off", stall_M, 0);
        check("st_regw", RegWrite_W, 0);
        dm_if.dm_req_ready = 1'b0;

        // LDUR with delayed ready and response
        aluResult_E = 64'h80; rd_E = 5'd5;
        MemRead_E = 1'b1; MemtoReg_E = 1'b1; RegWrite_E = 1'b1;
        tick();
        nop();
        check("ld_addr", dm_if.dm_addr, 64'h80);
        check("ld_we",   dm_if.dm_req_we, 0);
        stall_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            dm_if.dm_req_ready = rdy_tbl[i];
            dm_if.dm_rsp_valid = rsp_tbl[i];
            dm_if.dm_rdata     = rsp_tbl[i] ? 64'h1234 : 64'hBAD0;
            #1;
            check($sformatf("ld_stall_c%0d", i), stall_M, stl_tbl[i]);
            if (i > 0) check($sformatf("ld_bubble_c%0d", i), RegWrite_W, 0);
            if (stall_M) stall_cycles++;
            tick();
        end
        dm_if.dm_req_ready = 1'b0;
        dm_if.dm_rsp_valid = 1'b0;
        check("ld_stall_cnt", stall_cycles, 5);
        check("ld_rdata",  readData_W, 64'h1234);
        check("ld_m2r",    MemtoReg_W, 1);
        check("ld_regw",   RegWrite_W, 1);
        check("ld_rdw",    rd_W, 5);
        check("ld_idle",   stall_M, 0);

        // CBZ taken, then a flushed instruction
        Branch_E = 1'b1; zero_E = 1'b1; PCBranch_E = 64'h200;
        tick();
        check("br_pcsrc",  PCSrc_M, 1);
        check("br_target", PCBranch_M, 64'h200);
        nop();
        flush_M = 1'b1; Branch_E = 1'b1; zero_E = 1'b1; MemRead_E = 1'b1;
        RegWrite_E = 1'b1; MemtoReg_E = 1'b1; aluResult_E = 64'h8;
        tick();
        nop();
        check("fl_pcsrc", PCSrc_M, 0);
        check("fl_valid", dm_if.dm_req_valid, 0);
        check("fl_stall", stall_M, 0);
        tick();
        check("fl_regw", RegWrite_W, 0);
        check("fl_m2r",  MemtoReg_W, 0);

        // misaligned LDUR: no request, no stall, sticky fault
        dm_if.dm_req_ready = 1'b1;
        aluResult_E = 64'h43; rd_E = 5'd7;
        MemRead_E = 1'b1; MemtoReg_E = 1'b1; RegWrite_E = 1'b1;
        tick();
        nop();
        check("mis_valid", dm_if.dm_req_valid, 0);
        check("mis_stall", stall_M, 0);
        check("mis_fault_early", mem_fault, 0);
        tick();
        check("mis_fault", mem_fault, 1);
        check("mis_regw",  RegWrite_W, 0);
        check("mis_rdata", readData_W, 0);
        tick();
        tick();
        check("mis_sticky", mem_fault, 1);

        // reset while waiting for load data; the late response is ignored
        aluResult_E = 64'h100; rd_E = 5'd9;
        MemRead_E = 1'b1; MemtoReg_E = 1'b1; RegWrite_E = 1'b1;
        tick();
        nop();
        check("rw_req_stall", stall_M, 1);
        tick();
        dm_if.dm_req_ready = 1'b0;
        #1;
        check("rw_wait_stall", stall_M, 1);
        check("rw_wait_valid", dm_if.dm_req_valid, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dm_if.dm_rsp_valid = 1'b1;
        dm_if.dm_rdata     = 64'h5555;
        #1;
        check("rw_stall", stall_M, 0);
        check("rw_valid", dm_if.dm_req_valid, 0);
        check("rw_fault", mem_fault, 0);
        check("rw_regw",  RegWrite_W, 0);
        check("rw_aluw",  aluResult_W, 0);
        check("rw_rdw",   rd_W, 0);
        tick();
        dm_if.dm_rsp_valid = 1'b0;
        check("rw_late_rdata", readData_W, 0);
        check("rw_late_regw",  RegWrite_W, 0);
        check("rw_late_m2r",   MemtoReg_W, 0);

        // back-to-back stores: second request right after the first
        dm_if.dm_req_ready = 1'b1;
        aluResult_E = 64'h48; writeData_E = 64'h1; MemWrite_E = 1'b1;
        tick();
        aluResult_E = 64'h50; writeData_E = 64'h2;
        #1;
        check("b2b_valid1", dm_if.dm_req_valid, 1);
        check("b2b_addr1",  dm_if.dm_addr, 64'h48);
        check("b2b_stall1", stall_M, 0);
        tick();
        nop();
        #1;
        check("b2b_valid2", dm_if.dm_req_valid, 1);
        check("b2b_addr2",  dm_if.dm_addr, 64'h50);
        check("b2b_wdata2", dm_if.dm_wdata, 64'h2);
        tick();
        check("b2b_done", dm_if.dm_req_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- EX/MEM pipeline register plus memory-access stage of the 64-bit pipelined LEGv8 core.
- Latches execute-stage results and control, and drives a valid/ready data-memory port.
- Stalls upstream while a load or store is outstanding, resolves the conditional branch, and feeds a MEM/WB register to writeback.

Parameters:
N, 64, datapath width (address, ALU result, store/load data)
ALIGN_CHECK, 1, 1 = trap doubleword accesses with addr[2:0] != 0

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
aluResult_E  in  N  ALU result / memory address from execute
writeData_E  in  N  store data from execute
PCBranch_E  in  N  branch target from execute
zero_E  in  1  ALU zero flag
Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E  in  1 each  control bits
rd_E  in  5  destination register
flush_M  in  1  from hazard unit: latch a bubble instead of E contents
dm_req_valid  out  1  memory request valid
dm_req_we  out  1  1 = store, 0 = load
dm_addr  out  N  request address
dm_wdata  out  N  store data
dm_req_ready  in  1  memory accepts request
dm_rsp_valid  in  1  load data valid
dm_rdata  in  N  load data
stall_M  out  1  hold PC, IF/ID, ID/EX and the E inputs
PCSrc_M  out  1  take branch
PCBranch_M  out  N  latched branch target
mem_fault  out  1  sticky misaligned-access flag
aluResult_W, readData_W  out  N  writeback operands
RegWrite_W, MemtoReg_W  out  1  writeback control
rd_W  out  5  writeback destination

Behaviour:
- Reset (sync, active-high, priority over everything):
  - All M-latch fields and all *_W outputs are 0.
  - FSM goes to IDLE.
  - dm_req_valid = 0, stall_M = 0, PCSrc_M = 0, mem_fault = 0.
- EX/MEM latch:
  - On each clk edge with !stall_M, captures all *_E inputs.
  - If flush_M = 1, control bits are latched as 0; data fields are don't-care.
  - flush_M is ignored while stall_M = 1 (cannot coincide by construction).
- memop_M = MemRead_M | MemWrite_M.
- Misalignment:
  - misal_M = ALIGN_CHECK & memop_M & (aluResult_M[2:0] != 0).
  - A misaligned op issues no request and causes no stall.
  - Its RegWrite is suppressed in WB.
  - mem_fault sets the following cycle and stays set until reset.
- FSM states IDLE, REQ, WAIT:
  - Entered on the latching edge: REQ if the newly latched op has memop & !misal, else IDLE.
  - REQ: dm_req_valid = 1, dm_req_we = MemWrite_M, dm_addr = aluResult_M, dm_wdata = writeData_M.
    - Store with ready: access completes this cycle.
    - Load with ready: next state WAIT.
    - Not ready: hold REQ with the request signals stable.
  - WAIT: dm_req_valid = 0. On dm_rsp_valid, load completes this cycle. The response is never sampled in the accept cycle (minimum 1-cycle load latency).
  - On completion: next state from the newly latched instruction (REQ or IDLE).
- stall_M is combinational:
  - stall_M = (REQ & !(dm_req_ready & MemWrite_M)) | (WAIT & !dm_rsp_valid).
  - IDLE never stalls.
  - Store latency 0 extra cycles if ready at first request; load at least 1 extra stall cycle.
- Branch:
  - PCSrc_M = Branch_M & zero_M (combinational from the latch).
  - PCBranch_M = latched PCBranch_E.
  - Branch ops are never memory ops, so PCSrc_M never coincides with stall_M.
- MEM/WB register:
  - !stall_M: capture aluResult_M, readData = dm_rdata (load) or 0, RegWrite_M & !misal_M, MemtoReg_M, rd_M.
  - stall_M: inserts a bubble (RegWrite_W = 0, MemtoReg_W = 0); data fields hold.
- Reset mid-access: the outstanding request is dropped (dm_req_valid falls next cycle), and any late dm_rsp_valid after reset is ignored in IDLE.
- Back-to-back memory ops: the second op's request is asserted in the cycle after the first completes, with no idle gap.

Test Plan:
- ADD, aluResult_E = 0x10, rd = 3, RegWrite = 1 -> no stall; two edges later RegWrite_W = 1, aluResult_W = 0x10, rd_W = 3.
- STUR to addr 0x40, data 0xDEAD, ready = 1 immediately -> dm_req_valid = 1 and we = 1 for one cycle, stall_M = 0 throughout.
- LDUR to addr 0x80, ready after 2 cycles, rsp_valid 3 cycles later -> stall_M high for 5 cycles, one bubble in WB per stall cycle, then readData_W = dm_rdata = 0x1234, MemtoReg_W = 1.
- CBZ with zero_E = 1, PCBranch_E = 0x200 -> PCSrc_M = 1 for exactly one cycle with PCBranch_M = 0x200; with flush_M = 1 the next latched op has all control bits 0.
- LDUR to addr 0x43 with ALIGN_CHECK = 1 -> no dm_req_valid, no stall, RegWrite_W = 0, mem_fault = 1 and sticky until reset.
- Reset asserted while in WAIT, then dm_rsp_valid = 1 -> after reset: state IDLE, stall_M = 0, all *_W outputs 0, response ignored.
